// File: rtl/ps2_host_ctrl.sv
// PS/2 host port: receives device frames into a small FIFO and sends host
// commands with inhibit/request-to-send, ACK check, timeouts and retry.
module ps2_host_ctrl #(
   parameter int CLK_FREQ_HZ   = 50_000_000,
   parameter int INHIBIT_US    = 100,
   parameter int START_TMO_US  = 15000,
   parameter int FRAME_TMO_US  = 2000,
   parameter int RX_FIFO_DEPTH = 4,
   parameter int MAX_RETRY     = 2
) (
   input  logic       CLK50MHZ,
   input  logic       RST,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_out,
   output logic       ps2_data_out,
   output logic       ps2_clk_z,
   output logic       ps2_data_z,
   input  logic       cmd_trig,
   input  logic [7:0] cmd,
   output logic       cmd_busy,
   output logic       cmd_done,
   output logic       cmd_err,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_err,
   output logic       rx_overflow
);
   localparam longint INH_CYC = longint'(INHIBIT_US)   * longint'(CLK_FREQ_HZ) / 1_000_000;
   localparam longint STA_CYC = longint'(START_TMO_US) * longint'(CLK_FREQ_HZ) / 1_000_000;
   localparam longint FRM_CYC = longint'(FRAME_TMO_US) * longint'(CLK_FREQ_HZ) / 1_000_000;
   localparam int INH_W = $clog2(INH_CYC);
   localparam int STA_W = $clog2(STA_CYC);
   localparam int FRM_W = $clog2(FRM_CYC);
   localparam int MAX_W = (INH_W > STA_W) ? ((INH_W > FRM_W) ? INH_W : FRM_W)
                                          : ((STA_W > FRM_W) ? STA_W : FRM_W);
   localparam int TMR_W = (MAX_W > 0) ? MAX_W : 1;
   localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INH_CYC - 1);
   localparam logic [TMR_W-1:0] STA_LAST = TMR_W'(STA_CYC - 1);
   localparam logic [TMR_W-1:0] FRM_LAST = TMR_W'(FRM_CYC - 1);
   localparam int ATT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRY);
   localparam int AW = $clog2(RX_FIFO_DEPTH);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RX      = 3'd1;
   localparam logic [2:0] ST_INHIBIT = 3'd2;
   localparam logic [2:0] ST_REQ     = 3'd3;
   localparam logic [2:0] ST_TX      = 3'd4;
   localparam logic [2:0] ST_ACKW    = 3'd5;
   localparam logic [2:0] ST_FAIL    = 3'd6;

   logic [2:0]       state;
   logic             clk_s1, clk_s2, clk_prev, data_s1, data_s2;
   logic [TMR_W-1:0] tmr;
   logic [3:0]       bit_cnt;
   logic [ATT_W-1:0] attempt;
   logic [7:0]       cmd_lat;
   logic [7:0]       rx_sr;
   logic             rx_par;
   logic             req_rel;
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [7:0]       mem [RX_FIFO_DEPTH];
   logic             fall, trig_ok, fifo_empty, fifo_full, rx_pop, rx_good, rx_push;

   // rx_valid/rx_ready: the head byte moves on every clock edge where both are
   // high; rx_data holds steady while rx_valid=1 and rx_ready=0.
   always_comb begin
      fall       = clk_prev & ~clk_s2;
      trig_ok    = cmd_trig & ~cmd_busy;
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      rx_pop     = rx_ready & ~fifo_empty;
      rx_good    = (^{rx_sr, rx_par}) & data_s2;
      rx_push    = (state == ST_RX) & fall & (bit_cnt == 4'd10) & rx_good & ~trig_ok;
   end

   assign rx_valid = ~fifo_empty;
   assign rx_data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         {clk_s1, clk_s2, clk_prev, data_s1, data_s2} <= 5'b11111;
         state <= ST_IDLE;
         tmr <= '0;
         bit_cnt <= '0;
         attempt <= '0;
         cmd_lat <= '0;
         rx_sr <= '0;
         rx_par <= 1'b0;
         req_rel <= 1'b0;
         {ps2_clk_z, ps2_clk_out, ps2_data_z, ps2_data_out} <= 4'b1111;
         {cmd_busy, cmd_done, cmd_err, rx_err} <= 4'b0000;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= ps2_data;
         data_s2  <= data_s1;
         cmd_done <= 1'b0;
         cmd_err  <= 1'b0;
         rx_err   <= 1'b0;
         tmr      <= tmr + TMR_W'(1);
         // A command request aborts any frame being received, without rx_err.
         if (trig_ok && (state == ST_IDLE || state == ST_RX)) begin
            state       <= ST_INHIBIT;
            cmd_lat     <= cmd;
            attempt     <= '0;
            cmd_busy    <= 1'b1;
            tmr         <= '0;
            ps2_clk_z   <= 1'b0;
            ps2_clk_out <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (fall && !data_s2) begin
                  state   <= ST_RX;
                  bit_cnt <= 4'd1;
                  tmr     <= '0;
               end
               ST_RX: if (fall) begin
                  tmr     <= '0;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt <= 4'd8) rx_sr <= {data_s2, rx_sr[7:1]};
                  else if (bit_cnt == 4'd9) rx_par <= data_s2;
                  else begin
                     state  <= ST_IDLE;
                     rx_err <= ~rx_good;
                  end
               end else if (tmr == FRM_LAST) begin
                  rx_err <= 1'b1;
                  state  <= ST_IDLE;
               end
               ST_INHIBIT: if (tmr == INH_LAST) begin
                  state        <= ST_REQ;
                  req_rel      <= 1'b0;
                  ps2_data_z   <= 1'b0;
                  ps2_data_out <= 1'b0;
               end
               ST_REQ: if (!req_rel) begin
                  req_rel     <= 1'b1;
                  ps2_clk_z   <= 1'b1;
                  ps2_clk_out <= 1'b1;
                  tmr         <= '0;
               end else if (fall) begin
                  state        <= ST_TX;
                  bit_cnt      <= 4'd1;
                  tmr          <= '0;
                  ps2_data_out <= cmd_lat[0];
               end else if (tmr == STA_LAST) begin
                  state <= ST_FAIL;
               end
               // bit_cnt holds the number of falling edges already seen.
               ST_TX: if (fall) begin
                  tmr     <= '0;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt <= 4'd7) ps2_data_out <= cmd_lat[bit_cnt[2:0]];
                  else if (bit_cnt == 4'd8) ps2_data_out <= ~^cmd_lat;
                  else if (bit_cnt == 4'd9) begin
                     ps2_data_z   <= 1'b1;
                     ps2_data_out <= 1'b1;
                  end else state <= data_s2 ? ST_FAIL : ST_ACKW;
               end else if (tmr == FRM_LAST) begin
                  state <= ST_FAIL;
               end
               ST_ACKW: if (clk_s2 && data_s2) begin
                  cmd_done <= 1'b1;
                  cmd_busy <= 1'b0;
                  state    <= ST_IDLE;
               end else if (tmr == FRM_LAST) begin
                  state <= ST_FAIL;
               end
               ST_FAIL: begin
                  ps2_data_z   <= 1'b1;
                  ps2_data_out <= 1'b1;
                  if (attempt < ATT_MAX) begin
                     attempt     <= attempt + ATT_W'(1);
                     state       <= ST_INHIBIT;
                     tmr         <= '0;
                     ps2_clk_z   <= 1'b0;
                     ps2_clk_out <= 1'b0;
                  end else begin
                     cmd_err     <= 1'b1;
                     cmd_busy    <= 1'b0;
                     state       <= ST_IDLE;
                     ps2_clk_z   <= 1'b1;
                     ps2_clk_out <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rx_overflow <= 1'b0;
         for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         rx_overflow <= rx_push & fifo_full & ~rx_pop;
         if (rx_push && (!fifo_full || rx_pop)) begin
            mem[wr_ptr[AW-1:0]] <= rx_sr;
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (rx_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl: a behavioural PS/2 device on a wired-AND
// bus, pulse/pop monitors, and hand-computed expectations.
module tb_ps2_host_ctrl;
   localparam int HALF      = 20;
   localparam int INH_CYC   = 5000;   // 100 us at 50 MHz
   localparam int START_CYC = 5000;   // 100 us at 50 MHz
   localparam int FRAME_CYC = 1000;   // 20 us at 50 MHz

   logic       CLK50MHZ = 1'b0;
   logic       RST = 1'b1;
   logic       ps2_clk, ps2_data;
   logic       ps2_clk_out, ps2_data_out, ps2_clk_z, ps2_data_z;
   logic       cmd_trig = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       cmd_busy, cmd_done, cmd_err;
   logic [7:0] rx_data;
   logic       rx_valid, rx_err, rx_overflow;
   logic       rx_ready = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0, err_cnt = 0, rxerr_cnt = 0, ovf_cnt = 0, pop_cnt = 0;
   int inh_run = 0, inh_cnt = 0, last_inh = 0;
   logic [7:0] pop_log[$];
   logic [7:0] exp_q[$];

   ps2_host_ctrl #(
      .CLK_FREQ_HZ(50_000_000), .INHIBIT_US(100), .START_TMO_US(100),
      .FRAME_TMO_US(20), .RX_FIFO_DEPTH(4), .MAX_RETRY(2)
   ) dut (
      .CLK50MHZ(CLK50MHZ), .RST(RST), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
      .ps2_clk_z(ps2_clk_z), .ps2_data_z(ps2_data_z),
      .cmd_trig(cmd_trig), .cmd(cmd), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
      .cmd_err(cmd_err), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_err(rx_err), .rx_overflow(rx_overflow)
   );

   // Open-collector bus: either side may pull a line low.
   assign ps2_clk  = ps2_clk_z  ? dev_clk  : (ps2_clk_out  & dev_clk);
   assign ps2_data = ps2_data_z ? dev_data : (ps2_data_out & dev_data);

   always #10 CLK50MHZ = ~CLK50MHZ;

   always @(posedge CLK50MHZ) begin
      if (cmd_done) done_cnt++;
      if (cmd_err) err_cnt++;
      if (rx_err) rxerr_cnt++;
      if (rx_overflow) ovf_cnt++;
      if (rx_valid && rx_ready) begin
         pop_cnt++;
         pop_log.push_back(rx_data);
      end
      if (!ps2_clk_z) inh_run++;
      else begin
         if (inh_run != 0) begin
            last_inh = inh_run;
            inh_cnt++;
         end
         inh_run = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK50MHZ);
   endtask

   task automatic dev_pulse();
      cycles(HALF);
      dev_clk = 1'b0;
      cycles(HALF);
      dev_clk = 1'b1;
   endtask

   // Device-to-host: frame bits LSB first (start, D0..D7, P, stop), first nbits only.
   task automatic dev_send(input logic [10:0] frame, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         dev_data = frame[i];
         dev_pulse();
      end
      dev_data = 1'b1;
      cycles(HALF);
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic p);
      return {1'b1, p, b, 1'b0};
   endfunction

   task automatic pulse_cmd(input logic [7:0] c);
      @(negedge CLK50MHZ);
      cmd_trig = 1'b1;
      cmd = c;
      @(negedge CLK50MHZ);
      cmd_trig = 1'b0;
   endtask

   // Host-to-device: checks the inhibit phase and start bit, clocks in the
   // byte, parity and stop, then answers ACK (nack=0) or NACK (nack=1).
   task automatic dev_recv(input logic nack, output logic [7:0] b, output logic p, output logic s);
      logic [9:0] bits;
      int n;
      n = 0;
      while (ps2_clk_z && n < 20000) begin @(negedge CLK50MHZ); n++; end
      n = 0;
      while (!ps2_clk_z && n < 20000) begin @(negedge CLK50MHZ); n++; end
      cycles(2);
      check("inhibit_min", 32'(last_inh >= INH_CYC), 1);
      check("inhibit_max", 32'(last_inh <= INH_CYC + 2), 1);
      check("start_bit", 32'(ps2_data), 0);
      for (int i = 0; i < 10; i++) begin
         dev_pulse();
         bits[i] = ps2_data;
      end
      dev_data = nack;
      dev_pulse();
      dev_data = 1'b1;
      b = bits[7:0];
      p = bits[8];
      s = bits[9];
   endtask

   initial begin
      logic [7:0] b;
      logic p, s;
      int n, d0, e0, r0, o0, p0, i0, base;

      // reset
      @(negedge CLK50MHZ);
      RST = 1'b0;
      cycles(3);
      check("rst_clk_z", 32'(ps2_clk_z), 1);
      RST = 1'b1;
      cycles(2);
      check("rst_data_z", 32'(ps2_data_z), 1);
      check("rst_outs", 32'({ps2_clk_out, ps2_data_out}), 32'h3);
      check("rst_busy", 32'(cmd_busy), 0);
      check("rst_pulses", 32'({cmd_done, cmd_err, rx_err, rx_overflow}), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_rx_data", 32'(rx_data), 0);

      // good frame 0x1C, odd parity P=0, consumer always ready
      rx_ready = 1'b1;
      p0 = pop_cnt; r0 = rxerr_cnt;
      dev_send(mk_frame(8'h1C, 1'b0), 11);
      check("rx_pop_once", 32'(pop_cnt - p0), 1);
      check("rx_byte_1c", 32'(pop_log[pop_log.size()-1]), 32'h1C);
      check("rx_no_err", 32'(rxerr_cnt - r0), 0);

      // parity error
      p0 = pop_cnt; r0 = rxerr_cnt;
      dev_send(mk_frame(8'h1C, 1'b1), 11);
      check("par_err", 32'(rxerr_cnt - r0), 1);
      check("par_no_push", 32'(pop_cnt - p0), 0);
      check("par_empty", 32'(rx_valid), 0);

      // frame stalls after D2: frame timeout
      r0 = rxerr_cnt;
      dev_send(mk_frame(8'h33, 1'b1), 4);
      cycles(FRAME_CYC + 100);
      check("rx_tmo_err", 32'(rxerr_cnt - r0), 1);
      check("rx_tmo_empty", 32'(rx_valid), 0);

      // five frames into a depth-4 FIFO with no consumer
      rx_ready = 1'b0;
      o0 = ovf_cnt;
      for (int k = 1; k <= 5; k++) begin
         b = 8'(k);
         dev_send(mk_frame(b, ~^b), 11);
         if (k <= 4) exp_q.push_back(b);
      end
      check("ovf_once", 32'(ovf_cnt - o0), 1);
      check("ovf_valid", 32'(rx_valid), 1);
      check("ovf_head", 32'(rx_data), 32'h01);
      base = pop_log.size();
      p0 = pop_cnt;
      rx_ready = 1'b1;
      cycles(6);
      rx_ready = 1'b0;
      check("drain_count", 32'(pop_cnt - p0), 4);
      for (int k = 0; k < 4; k++) begin
         if (base + k < pop_log.size()) check("drain_byte", 32'(pop_log[base+k]), 32'(exp_q.pop_front()));
         else check("drain_missing", 0, 1);
      end
      check("drain_empty", 32'(rx_valid), 0);

      // command 0xED with ACK; a second trigger while busy is ignored
      d0 = done_cnt; e0 = err_cnt;
      pulse_cmd(8'hED);
      check("busy_rise", 32'(cmd_busy), 1);
      check("inhibit_start", 32'(ps2_clk_z), 0);
      pulse_cmd(8'h55);
      dev_recv(1'b0, b, p, s);
      check("tx_byte", 32'(b), 32'hED);
      check("tx_parity", 32'(p), 1);
      check("tx_stop", 32'(s), 1);
      n = 0;
      while (done_cnt == d0 && n < 200) begin @(negedge CLK50MHZ); n++; end
      cycles(20);
      check("ack_done", 32'(done_cnt - d0), 1);
      check("ack_no_err", 32'(err_cnt - e0), 0);
      check("ack_busy_low", 32'(cmd_busy), 0);
      check("ack_released", 32'({ps2_clk_z, ps2_data_z}), 32'h3);

      // NACK on every attempt: three inhibit phases then cmd_err
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
      pulse_cmd(8'hF4);
      for (int a = 0; a < 3; a++) begin
         dev_recv(1'b1, b, p, s);
         check("nack_byte", 32'(b), 32'hF4);
      end
      n = 0;
      while (err_cnt == e0 && n < 20000) begin @(negedge CLK50MHZ); n++; end
      cycles(50);
      check("nack_err", 32'(err_cnt - e0), 1);
      check("nack_no_done", 32'(done_cnt - d0), 0);
      check("nack_inhibits", 32'(inh_cnt - i0), 3);
      check("nack_busy_low", 32'(cmd_busy), 0);

      // cmd_trig at RX bit 4, device silent afterwards: start timeouts
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = rxerr_cnt;
      dev_send(mk_frame(8'hA5, 1'b1), 5);
      pulse_cmd(8'hF2);
      check("abort_inhibit", 32'(ps2_clk_z), 0);
      n = 0;
      while (err_cnt == e0 && n < 3 * (INH_CYC + START_CYC) + 5000) begin @(negedge CLK50MHZ); n++; end
      cycles(20);
      check("tmo_err", 32'(err_cnt - e0), 1);
      check("tmo_no_done", 32'(done_cnt - d0), 0);
      check("tmo_inhibits", 32'(inh_cnt - i0), 3);
      check("abort_no_rx_err", 32'(rxerr_cnt - r0), 0);
      check("tmo_released", 32'({ps2_clk_z, ps2_data_z}), 32'h3);

      // reset in the middle of a transmit
      d0 = done_cnt; e0 = err_cnt;
      pulse_cmd(8'hAA);
      n = 0;
      while (!ps2_clk_z && n < INH_CYC + 100) begin @(negedge CLK50MHZ); n++; end
      for (int k = 0; k < 3; k++) dev_pulse();
      check("midtx_driving", 32'(ps2_data_z), 0);
      RST = 1'b0;
      #1;
      check("midtx_rst_z", 32'({ps2_clk_z, ps2_data_z}), 32'h3);
      check("midtx_rst_busy", 32'(cmd_busy), 0);
      cycles(3);
      RST = 1'b1;
      cycles(200);
      check("midtx_no_err", 32'(err_cnt - e0), 0);
      check("midtx_no_done", 32'(done_cnt - d0), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
